// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel PWM LED driver with double-buffered duties.
// Samples arrive over a valid/ready handshake into a shadow buffer. The
// buffer is copied into the active duties only at a PWM period boundary, so a
// new colour never starts in the middle of a period.
// Optional build macro: RGB_PWM_ACTIVE_LOW_EN inverts RGB_R/G/B after the
// output register, for LED pins that sink current.

module rgb_pwm_driver #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 47
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PWM_BITS-1:0] in_r,
    input  logic [PWM_BITS-1:0] in_g,
    input  logic [PWM_BITS-1:0] in_b,
    output logic                period_start,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);

    localparam int PRE_W = $clog2(PRESCALE + 1);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = {PWM_BITS{1'b1}};

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] shadow_r, shadow_g, shadow_b;
    logic [PWM_BITS-1:0] active_r, active_g, active_b;
    logic                pending;
    logic [2:0]          rgb_q;

    logic tick;
    logic boundary;
    logic accept;

    // Handshake: a sample transfers on any clk edge where in_valid and
    // in_ready are both high. in_ready is high whenever the shadow buffer is
    // free (no sample waiting for a boundary) and rst is low. While in_ready
    // is low the upstream keeps offering; nothing is dropped or overwritten,
    // and the upstream may change its data freely until the transfer edge.
    assign in_ready = !pending && !rst;
    assign accept   = in_valid && in_ready;

    assign tick     = (pre_cnt == PRE_LAST);
    assign boundary = tick && (pwm_cnt == PWM_LAST);

    // Prescaler: one PWM tick every PRESCALE clk cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // PWM counter: advances on each tick and wraps naturally at the boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (tick) begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Double buffer: capture into shadow on transfer, commit to active at the
    // boundary. A transfer in the boundary cycle itself only fills the shadow
    // (pending was 0, so there is nothing to commit); it waits a full period.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= '0;
            shadow_g <= '0;
            shadow_b <= '0;
            active_r <= '0;
            active_g <= '0;
            active_b <= '0;
            pending  <= 1'b0;
        end else begin
            if (boundary && pending) begin
                active_r <= shadow_r;
                active_g <= shadow_g;
                active_b <= shadow_b;
                pending  <= 1'b0;
            end
            if (accept) begin
                shadow_r <= in_r;
                shadow_g <= in_g;
                shadow_b <= in_b;
                pending  <= 1'b1;
            end
        end
    end

    // Output register: PWM compare plus the frame tick, both one cycle
    // behind the counter so they line up with each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q        <= 3'b000;
            period_start <= 1'b0;
        end else begin
            rgb_q        <= {(pwm_cnt < active_r),
                             (pwm_cnt < active_g),
                             (pwm_cnt < active_b)};
            period_start <= boundary;
        end
    end

`ifdef RGB_PWM_ACTIVE_LOW_EN
    assign {RGB_R, RGB_G, RGB_B} = ~rgb_q;
`else
    assign {RGB_R, RGB_G, RGB_B} = rgb_q;
`endif

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Testbench for rgb_pwm_driver with PRESCALE=2, PWM_BITS=4 (32-cycle period).
// The driver keeps a period-level reference model: a sample is accepted when
// no earlier sample is still waiting, and a waiting sample becomes the colour
// of the period that starts after the next period boundary. At every boundary
// the colour of the coming period is pushed onto exp_q. The monitor pops one
// colour per period_start pulse and checks that in the following 32 cycles
// each channel is on for exactly its first duty*PRESCALE cycles.

module tb_rgb_pwm_driver;

    localparam int PWM_BITS = 4;
    localparam int PRESCALE = 2;
    localparam int PERIOD   = PRESCALE * (1 << PWM_BITS);
    localparam int W        = 3 * PWM_BITS;

`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [PWM_BITS-1:0] in_r, in_g, in_b;
    logic                period_start;
    logic                RGB_R, RGB_G, RGB_B;

    rgb_pwm_driver #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_r         (in_r),
        .in_g         (in_g),
        .in_b         (in_b),
        .period_start (period_start),
        .RGB_R        (RGB_R),
        .RGB_G        (RGB_G),
        .RGB_B        (RGB_B)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // reference model
    int           cyc_n     = 0;     // cycles since the last reset edge
    logic         m_pending = 1'b0;
    logic [W-1:0] m_shadow  = '0;
    logic [W-1:0] m_active  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs are already driven; check in_ready against the
    // model, advance the model, then move to the next negedge.
    task automatic step();
        logic exp_ready;
        #1;
        if (rst) begin
            chk("in_ready_rst", 32'(in_ready), 32'(0));
            m_pending = 1'b0;
            m_shadow  = '0;
            m_active  = '0;
            cyc_n     = 0;
            exp_q.delete();
        end else begin
            exp_ready = !m_pending;
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            if ((cyc_n % PERIOD) == PERIOD - 1) begin
                if (m_pending) begin
                    m_active  = m_shadow;
                    m_pending = 1'b0;
                end
                exp_q.push_back(m_active);
            end
            if (in_valid && exp_ready) begin
                m_shadow  = {in_r, in_g, in_b};
                m_pending = 1'b1;
            end
            cyc_n++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Offer a sample until accepted. While the driver is expected to stall,
    // junk data is presented to make sure nothing but the accepted sample lands.
    task automatic send(input logic [PWM_BITS-1:0] r, g, b);
        int  waited = 0;
        logic done  = 1'b0;
        while (!done) begin
            in_valid = 1'b1;
            if (m_pending) {in_r, in_g, in_b} = W'($urandom);
            else           {in_r, in_g, in_b} = {r, g, b};
            done = !m_pending;
            step();
            waited++;
            if (!done && waited > 3 * PERIOD) begin
                checks++;
                errors++;
                $display("FAIL send_timeout waited %0d cycles limit %0d", waited, 3 * PERIOD);
                done = 1'b1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_boundary_cycle();
        int n = 0;
        while (!(((cyc_n % PERIOD) == PERIOD - 1) && !m_pending) && n < 4 * PERIOD) begin
            step();
            n++;
        end
    endtask

    // ---------------- monitor ----------------
    function automatic logic on_bit(input int k, input logic [PWM_BITS-1:0] d);
        return (k - 1) < PRESCALE * int'(d);
    endfunction

    initial begin
        logic         have_win;
        int           win_k;
        int           mon_k;
        logic [W-1:0] cur;
        logic [2:0]   exp_bits;
        have_win = 1'b0;
        win_k    = 0;
        mon_k    = 0;
        cur      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                have_win = 1'b0;
                mon_k    = 0;
                chk("rst_rgb", 32'({RGB_R, RGB_G, RGB_B}), 32'({3{INV}}));
                chk("rst_pstart", 32'(period_start), 32'(0));
            end else begin
                mon_k++;
                if (have_win) begin
                    win_k++;
                    exp_bits = {on_bit(win_k, cur[W-1 -: PWM_BITS]),
                                on_bit(win_k, cur[2*PWM_BITS-1 -: PWM_BITS]),
                                on_bit(win_k, cur[PWM_BITS-1:0])} ^ {3{INV}};
                    chk("pwm_out", 32'({RGB_R, RGB_G, RGB_B}), 32'(exp_bits));
                    if (win_k == PERIOD) have_win = 1'b0;
                end else begin
                    chk("idle_out", 32'({RGB_R, RGB_G, RGB_B}), 32'({3{INV}}));
                end
                if (period_start) begin
                    chk("pstart_gap", 32'(mon_k), 32'(PERIOD));
                    mon_k = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pstart_unexpected got pulse expected none at %0t", $time);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_win = 1'b1;
                        win_k    = 0;
                    end
                end else if (mon_k == PERIOD + 1) begin
                    checks++;
                    errors++;
                    $display("FAIL pstart_missing got none after %0d cycles expected pulse", mon_k);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_r     = '0;
        in_g     = '0;
        in_b     = '0;
        idle(3);
        rst = 1'b0;

        // idle after reset: outputs off, pulses every period
        idle(100);

        // single sample, including both duty extremes
        send(4'd4, 4'd0, 4'd15);
        idle(3 * PERIOD);

        // back-to-back samples: second stalls until the boundary
        send(4'd8, 4'd0, 4'd0);
        send(4'd2, 4'd0, 4'd0);
        idle(3 * PERIOD);

        // sample offered exactly in the boundary cycle
        wait_boundary_cycle();
        send(4'd0, 4'd1, 4'd0);
        idle(3 * PERIOD);

        // reset mid-period with a sample pending
        send(4'd10, 4'd0, 4'd0);
        idle(2 * PERIOD);
        send(4'd5, 4'd5, 4'd5);
        idle(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(2 * PERIOD + 5);

        // randomized traffic
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) wait_boundary_cycle();
            else idle($urandom_range(0, 45));
            send(PWM_BITS'($urandom_range(0, 15)),
                 PWM_BITS'($urandom_range(0, 15)),
                 PWM_BITS'($urandom_range(0, 15)));
        end
        idle(2 * PERIOD + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
